// File: rtl/freq_sweep.sv
// Linear frequency sweep driving the NCO phase-increment word.
// Modes: single up-sweep, repeating sawtooth, continuous triangle.
module freq_sweep #(
   parameter int FREQ_W  = 32,
   parameter int DWELL_W = 24
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [1:0]         i_mode,
   input  logic [FREQ_W-1:0]  i_f_start,
   input  logic [FREQ_W-1:0]  i_f_stop,
   input  logic [FREQ_W-1:0]  i_f_step,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [FREQ_W-1:0]  o_freq,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_step_strobe
);

   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

   state_t               r_state;
   logic [1:0]           r_mode;
   logic [FREQ_W-1:0]    r_fstart;
   logic [FREQ_W-1:0]    r_fstop;
   logic [FREQ_W-1:0]    r_fstep;
   logic [DWELL_W-1:0]   r_dwell;
   logic [DWELL_W-1:0]   r_cnt;
   logic                 r_degen;
   logic [FREQ_W-1:0]    r_freq;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_strobe;

   logic [FREQ_W:0]      w_sum;
   logic [FREQ_W-1:0]    w_up;
   logic [FREQ_W-1:0]    w_diff;
   logic [FREQ_W-1:0]    w_dn;
   logic [DWELL_W-1:0]   w_ld_dwell;
   logic                 w_saw;
   logic                 w_tri;

   // Counter holds dwell-1 so each value is visible exactly max(dwell,1) cycles.
   assign w_ld_dwell = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
   assign w_saw      = (r_mode == 2'b01);
   assign w_tri      = (r_mode == 2'b10);

   always_comb begin
      w_sum  = {1'b0, r_freq} + {1'b0, r_fstep};
      w_up   = (w_sum[FREQ_W] || (w_sum[FREQ_W-1:0] >= r_fstop)) ? r_fstop
                                                                 : w_sum[FREQ_W-1:0];
      w_diff = r_freq - r_fstart;
      w_dn   = (w_diff <= r_fstep) ? r_fstart : (r_freq - r_fstep);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_mode   <= '0;
         r_fstart <= '0;
         r_fstop  <= '0;
         r_fstep  <= '0;
         r_dwell  <= '0;
         r_cnt    <= '0;
         r_degen  <= 1'b0;
         r_freq   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_strobe <= 1'b0;
         if (i_abort) begin
            r_state <= S_IDLE;
            r_freq  <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_mode   <= i_mode;
                     r_fstart <= i_f_start;
                     r_fstop  <= i_f_stop;
                     r_fstep  <= i_f_step;
                     r_dwell  <= w_ld_dwell;
                     r_cnt    <= w_ld_dwell;
                     // Empty or inverted range: park at f_start, never step.
                     r_degen  <= (i_f_start >= i_f_stop) || (i_f_step == '0);
                     r_freq   <= i_f_start;
                     r_strobe <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= S_UP;
                  end
               end
               S_UP: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - DWELL_W'(1);
                  end else begin
                     r_cnt <= r_dwell;
                     if (r_degen) begin
                        if (!w_saw && !w_tri) begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_cnt   <= '0;
                        end
                     end else if (r_freq == r_fstop) begin
                        if (w_saw) begin
                           r_freq   <= r_fstart;
                           r_strobe <= 1'b1;
                        end else if (w_tri) begin
                           r_state  <= S_DOWN;
                           r_freq   <= w_dn;
                           r_strobe <= (w_dn != r_freq);
                        end else begin
                           r_state <= S_IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                           r_cnt   <= '0;
                        end
                     end else begin
                        r_freq   <= w_up;
                        r_strobe <= (w_up != r_freq);
                     end
                  end
               end
               S_DOWN: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - DWELL_W'(1);
                  end else begin
                     r_cnt <= r_dwell;
                     if (r_freq == r_fstart) begin
                        r_state  <= S_UP;
                        r_freq   <= w_up;
                        r_strobe <= (w_up != r_freq);
                     end else begin
                        r_freq   <= w_dn;
                        r_strobe <= (w_dn != r_freq);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_freq        = r_freq;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_step_strobe = r_strobe;

endmodule

// File: tb/tb_freq_sweep.sv
// Directed bench for freq_sweep: single, clamp, overflow, sawtooth/abort,
// triangle/reset, degenerate ranges and start/abort collisions.
module tb_freq_sweep;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [31:0] f_start;
   logic [31:0] f_stop;
   logic [31:0] f_step;
   logic [23:0] dwell;
   logic [31:0] freq;
   logic        busy;
   logic        done;
   logic        strobe;

   int n_tests = 0;
   int n_fail  = 0;

   freq_sweep #(.FREQ_W(32), .DWELL_W(24)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_abort      (abort),
      .i_mode       (mode),
      .i_f_start    (f_start),
      .i_f_stop     (f_stop),
      .i_f_step     (f_step),
      .i_dwell      (dwell),
      .o_freq       (freq),
      .o_busy       (busy),
      .o_done       (done),
      .o_step_strobe(strobe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a start pulse; returns one cycle after the sampling edge (T+1).
   task automatic go(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fp,
                     input logic [31:0] st, input logic [23:0] dw);
      mode = m; f_start = fs; f_stop = fp; f_step = st; dwell = dw;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Check a single-mode run of n values, each held d cycles, then done.
   task automatic run_seq(input string tag, input logic [3:0][31:0] vals,
                          input int n, input int d);
      for (int v = 0; v < n; v++) begin
         for (int j = 0; j < d; j++) begin
            chk({tag, "_freq"},   freq,   vals[v]);
            chk({tag, "_strobe"}, 32'(strobe), 32'(j == 0));
            chk({tag, "_busy"},   32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
         end
      end
      chk({tag, "_done"},      32'(done), 32'd1);
      chk({tag, "_idle"},      32'(busy), 32'd0);
      chk({tag, "_holdfreq"},  freq,      vals[n-1]);
      tick();
      chk({tag, "_donepulse"}, 32'(done), 32'd0);
      chk({tag, "_holdfreq2"}, freq,      vals[n-1]);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      tick(); tick();
      chk("rst_freq",   freq,         32'd0);
      chk("rst_busy",   32'(busy),    32'd0);
      chk("rst_done",   32'(done),    32'd0);
      chk("rst_strobe", 32'(strobe),  32'd0);
      rst = 1'b0;
      tick();

      // Single run, exact landing on f_stop
      go(2'b00, 32'h10000, 32'h40000, 32'h10000, 24'd3);
      run_seq("single", {32'h40000, 32'h30000, 32'h20000, 32'h10000}, 4, 3);

      // Clamp to f_stop
      go(2'b00, 32'h10000, 32'h38000, 32'h10000, 24'd3);
      run_seq("clamp", {32'h38000, 32'h30000, 32'h20000, 32'h10000}, 4, 3);

      // Carry out of the adder clamps to f_stop
      go(2'b00, 32'hFFFF0000, 32'hFFFFFFFF, 32'h20000, 24'd1);
      run_seq("ovf", {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFF0000}, 2, 1);

      // Sawtooth: 100,200,300,100,200; ignored start at T+2; abort in T+5
      go(2'b01, 32'h100, 32'h300, 32'h100, 24'd1);
      chk("saw_t1", freq, 32'h100);
      tick();
      chk("saw_t2", freq, 32'h200);
      f_start = 32'h7777; mode = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      chk("saw_t3", freq, 32'h300);
      tick();
      chk("saw_wrap",        freq,        32'h100);
      chk("saw_wrap_strobe", 32'(strobe), 32'd1);
      chk("saw_wrap_busy",   32'(busy),   32'd1);
      tick();
      chk("saw_t5", freq, 32'h200);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_freq",   freq,        32'd0);
      chk("abort_busy",   32'(busy),   32'd0);
      chk("abort_done",   32'(done),   32'd0);
      chk("abort_strobe", 32'(strobe), 32'd0);

      // Triangle, dwell 0 treated as 1
      go(2'b10, 32'd1, 32'd3, 32'd1, 24'd0);
      begin
         logic [6:0][31:0] tri_exp;
         tri_exp = {32'd3, 32'd2, 32'd1, 32'd2, 32'd3, 32'd2, 32'd1};
         for (int i = 0; i < 7; i++) begin
            chk("tri_freq",   freq,        tri_exp[i]);
            chk("tri_strobe", 32'(strobe), 32'd1);
            chk("tri_busy",   32'(busy),   32'd1);
            chk("tri_done",   32'(done),   32'd0);
            tick();
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("trirst_freq",   freq,        32'd0);
      chk("trirst_busy",   32'(busy),   32'd0);
      chk("trirst_done",   32'(done),   32'd0);
      chk("trirst_strobe", 32'(strobe), 32'd0);
      tick();

      // Degenerate single: step 0, one dwell then done, one strobe
      go(2'b00, 32'h500, 32'h900, 32'h0, 24'd2);
      begin
         int nstr;
         nstr = 0;
         for (int i = 0; i < 2; i++) begin
            chk("deg_freq", freq,      32'h500);
            chk("deg_busy", 32'(busy), 32'd1);
            nstr += int'(strobe);
            tick();
         end
         chk("deg_done",    32'(done), 32'd1);
         chk("deg_idle",    32'(busy), 32'd0);
         chk("deg_freqend", freq,      32'h500);
         nstr += int'(strobe);
         chk("deg_nstrobe", 32'(nstr), 32'd1);
      end
      tick();

      // Degenerate sawtooth: parks at f_start with no further strobes
      go(2'b01, 32'h700, 32'h700, 32'h1, 24'd1);
      chk("park_strobe0", 32'(strobe), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("park_freq",   freq,        32'h700);
         chk("park_strobe", 32'(strobe), 32'd0);
         chk("park_busy",   32'(busy),   32'd1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("park_abort_busy", 32'(busy), 32'd0);

      // start and abort together in IDLE: abort wins
      mode = 2'b00; f_start = 32'h1234; f_stop = 32'h5000; f_step = 32'h10; dwell = 24'd1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("collide_busy",   32'(busy),   32'd0);
      chk("collide_freq",   freq,        32'd0);
      chk("collide_strobe", 32'(strobe), 32'd0);
      tick();
      chk("collide_busy2",  32'(busy),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
